capture_buffer: RTL

- Downstream consumer of the logic-analyser trigger stage; samples the same 32-bit probe bus into a circular on-chip buffer.
- Keeps PRE_TRIG words before the trigger event and fills the remainder of the buffer after it.
- Once the capture is complete, it presents the captured window in time order through a simple read port to the host/readout logic.

---
 rtl/capture_buffer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/capture_buffer.sv
// Circular capture buffer behind the logic-analyser trigger stage: keeps PRE_TRIG
// words before the trigger, fills the rest after it, then reads the window out in time order.
module capture_buffer #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int PRE_TRIG   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] data,
  input  logic              start,
  input  logic              trigger,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              busy,
  output logic              triggered,
  output logic              done
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] PRE_CNT_END = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_INIT   = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] DEPTH_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT    = CW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFF     = AW'(PRE_TRIG);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     trig_addr_q, trig_addr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     pre_cnt_q, pre_cnt_d;
  logic [CW-1:0]     post_cnt_q, post_cnt_d;
  logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
  logic              triggered_q, triggered_d;
  logic              rearm_ok_q, rearm_ok_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              wr_en;

  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d     = state_q;
    data_d      = data;
    wr_ptr_d    = wr_ptr_q;
    trig_addr_d = trig_addr_q;
    rd_ptr_d    = rd_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    triggered_d = triggered_q;
    rearm_ok_d  = rearm_ok_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    wr_en       = 1'b0;

    if (!start) rearm_ok_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start && rearm_ok_q) begin
          wr_ptr_d    = '0;
          pre_cnt_d   = '0;
          triggered_d = 1'b0;
          state_d     = (PRE_TRIG == 0) ? S_ARMED : S_PRE;
        end
      end
      S_PRE: begin
        if (!start) begin
          state_d     = S_IDLE;
          triggered_d = 1'b0;
        end else begin
          wr_en     = 1'b1;
          wr_ptr_d  = wr_ptr_q + 1'b1;
          pre_cnt_d = pre_cnt_q + 1'b1;
          if (pre_cnt_d == PRE_CNT_END) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!start) begin
          state_d     = S_IDLE;
          triggered_d = 1'b0;
        end else begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (trigger) begin
            trig_addr_d = wr_ptr_q;
            triggered_d = 1'b1;
            post_cnt_d  = POST_INIT;
            state_d     = (POST_INIT == '0) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (!start) begin
          state_d     = S_IDLE;
          triggered_d = 1'b0;
        end else begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          post_cnt_d = post_cnt_q - 1'b1;
          if (post_cnt_d == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Leave only once the final read has had its cycle on the output.
        if (rd_cnt_q == DEPTH_CNT) begin
          state_d    = S_IDLE;
          rearm_ok_d = 1'b0;
        end else if (rd_en) begin
          rd_data_d  = mem[rd_ptr_q];
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_cnt_q == LAST_CNT);
          rd_ptr_d   = rd_ptr_q + 1'b1;
          rd_cnt_d   = rd_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Oldest kept word sits PRE_TRIG slots behind the trigger word.
    if (state_d == S_DONE && state_q != S_DONE) begin
      rd_ptr_d = trig_addr_d - PRE_OFF;
      rd_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      data_q      <= '0;
      wr_ptr_q    <= '0;
      trig_addr_q <= '0;
      rd_ptr_q    <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      triggered_q <= 1'b0;
      rearm_ok_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      wr_ptr_q    <= wr_ptr_d;
      trig_addr_q <= trig_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      triggered_q <= triggered_d;
      rearm_ok_q  <= rearm_ok_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= data_q;
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign triggered = triggered_q;
  assign done      = (state_q == S_DONE);

endmodule
